// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded fields, operands and control bits
// for EXE, with freeze (stall), flush (bubble insert) and a saturating bubble counter.
module id_exe_reg #(
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic [31:0]             PC_in,
  input  logic [31:0]             Val_Rn_in,
  input  logic [31:0]             Val_Rm_in,
  input  logic [11:0]             Shift_operand_in,
  input  logic [23:0]             Signed_imm_24_in,
  input  logic                    imm_in,
  input  logic [3:0]              Dest_in,
  input  logic [3:0]              src1_in,
  input  logic [3:0]              src2_in,
  input  logic [3:0]              EXE_CMD_in,
  input  logic                    MEM_R_EN_in,
  input  logic                    MEM_W_EN_in,
  input  logic                    WB_EN_in,
  input  logic                    B_in,
  input  logic                    S_in,
  input  logic [3:0]              SR_in,
  output logic                    valid_out,
  output logic [31:0]             PC_out,
  output logic [31:0]             Val_Rn_out,
  output logic [31:0]             Val_Rm_out,
  output logic [11:0]             Shift_operand_out,
  output logic [23:0]             Signed_imm_24_out,
  output logic                    imm_out,
  output logic [3:0]              Dest_out,
  output logic [3:0]              src1_out,
  output logic [3:0]              src2_out,
  output logic [3:0]              EXE_CMD_out,
  output logic                    MEM_R_EN_out,
  output logic                    MEM_W_EN_out,
  output logic                    WB_EN_out,
  output logic                    B_out,
  output logic                    S_out,
  output logic [3:0]              SR_out,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] shop;
    logic [23:0] imm24;
    logic        imm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb;
    logic        b;
    logic        s;
    logic [3:0]  sr;
    logic        valid;
  } stage_t;

  stage_t                  stage_in_s;
  stage_t                  stage_d;
  stage_t                  stage_q;
  logic [BUBBLE_CNT_W-1:0] cnt_d;
  logic [BUBBLE_CNT_W-1:0] cnt_q;
  logic                    cnt_sat_s;

  assign stage_in_s = '{pc: PC_in, rn: Val_Rn_in, rm: Val_Rm_in, shop: Shift_operand_in,
                        imm24: Signed_imm_24_in, imm: imm_in, dest: Dest_in,
                        src1: src1_in, src2: src2_in, cmd: EXE_CMD_in,
                        mem_r: MEM_R_EN_in, mem_w: MEM_W_EN_in, wb: WB_EN_in,
                        b: B_in, s: S_in, sr: SR_in, valid: valid_in};

  assign cnt_sat_s = (cnt_q == {BUBBLE_CNT_W{1'b1}});

  // Next-state selection: freeze beats flush; a flushed stage is fully zeroed.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (freeze) begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
    end else if (flush) begin
      stage_d = '0;
      cnt_d   = cnt_sat_s ? cnt_q : cnt_q + BUBBLE_CNT_W'(1);
    end else begin
      stage_d = stage_in_s;
      if (!valid_in && !cnt_sat_s) begin
        cnt_d = cnt_q + BUBBLE_CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Stage and counter flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out         = stage_q.valid;
  assign PC_out            = stage_q.pc;
  assign Val_Rn_out        = stage_q.rn;
  assign Val_Rm_out        = stage_q.rm;
  assign Shift_operand_out = stage_q.shop;
  assign Signed_imm_24_out = stage_q.imm24;
  assign imm_out           = stage_q.imm;
  assign Dest_out          = stage_q.dest;
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
  assign EXE_CMD_out       = stage_q.cmd;
  assign MEM_R_EN_out      = stage_q.mem_r;
  assign MEM_W_EN_out      = stage_q.mem_w;
  assign WB_EN_out         = stage_q.wb;
  assign B_out             = stage_q.b;
  assign S_out             = stage_q.s;
  assign SR_out            = stage_q.sr;
  assign bubble_cnt        = cnt_q;

endmodule
